// File: rtl/rv32_pkg_bus.sv
// Shared types for the rv32imc_ss memory-bus arbiter: FSM states, grant owner
// and the latched request that drives the unified memory port.
package rv32_pkg_bus;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
    typedef enum logic {GRANT_INSTR, GRANT_DATA} bus_grant_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef struct packed {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_req_t;

endpackage

// File: rtl/rv32_mod_bus_timeout.sv
// Saturating busy counter; expired stays high once TIMEOUT_CYCLES busy cycles
// have elapsed since the last clear. TIMEOUT_CYCLES = 0 disables it.
module rv32_mod_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Holding at LIMIT keeps the counter from wrapping into a false "fresh" state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LIMIT)
            count <= count + 1'b1;
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/rv32_mod_bus_arbiter.sv
// Shares one memory handshake port between the fetch and load/store masters,
// one transaction at a time, with bus-error abort on a hung response.
module rv32_mod_bus_arbiter
    import rv32_pkg_bus::*;
#(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_ack,
    output logic        instr_err,
    output logic [31:0] instr_data_i,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_o,
    output logic        data_ack,
    output logic        data_err,
    output logic [31:0] data_data_i,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_data_i
);

    arb_state_t state, state_nxt;
    bus_grant_t last_grant, last_grant_nxt;
    bus_req_t   instr_rq, data_rq, mem_rq, mem_rq_nxt;
    logic       mem_req_nxt;
    logic       grant_start, expired, data_wins, resp_ok, resp_err;

    assign instr_rq = '{wr: 1'b0, be: BE_WORD, addr: instr_addr, data: 32'h0};
    assign data_rq  = '{wr: data_wr, be: data_be, addr: data_addr, data: data_data_o};

    assign mem_wr     = mem_rq.wr;
    assign mem_be     = mem_rq.be;
    assign mem_addr   = mem_rq.addr;
    assign mem_data_o = mem_rq.data;

    rv32_mod_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_start),
        .enable  (state != IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_INSTR;
            mem_req    <= 1'b0;
            mem_rq     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            mem_req    <= mem_req_nxt;
            mem_rq     <= mem_rq_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_req_nxt    = mem_req;
        mem_rq_nxt     = mem_rq;
        grant_start    = 1'b0;
        instr_ack      = 1'b0;
        instr_err      = 1'b0;
        instr_data_i   = '0;
        data_ack       = 1'b0;
        data_err       = 1'b0;
        data_data_i    = '0;
        // Round-robin tie goes to data only if instr was served last.
        data_wins = data_req &&
                    (!instr_req || DATA_PRIORITY != 0 || last_grant == GRANT_INSTR);
        // A real response in the timeout cycle takes precedence over the abort.
        resp_ok  = mem_ack && !mem_err;
        resp_err = mem_err || (expired && !mem_ack);

        case (state)
            IDLE: begin
                if (data_wins) begin
                    state_nxt   = GRANT_D;
                    mem_rq_nxt  = data_rq;
                    mem_req_nxt = 1'b1;
                    grant_start = 1'b1;
                end else if (instr_req) begin
                    state_nxt   = GRANT_I;
                    mem_rq_nxt  = instr_rq;
                    mem_req_nxt = 1'b1;
                    grant_start = 1'b1;
                end
            end
            GRANT_I: begin
                // Gating by req drops the response if the master gave up.
                instr_ack    = instr_req && resp_ok;
                instr_err    = instr_req && resp_err;
                instr_data_i = mem_data_i;
                if (mem_ack || resp_err) begin
                    state_nxt      = IDLE;
                    mem_req_nxt    = 1'b0;
                    last_grant_nxt = GRANT_INSTR;
                end
            end
            GRANT_D: begin
                data_ack    = data_req && resp_ok;
                data_err    = data_req && resp_err;
                data_data_i = mem_data_i;
                if (mem_ack || resp_err) begin
                    state_nxt      = IDLE;
                    mem_req_nxt    = 1'b0;
                    last_grant_nxt = GRANT_DATA;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/rv32_mod_bus_arbiter.md
# rv32_mod_bus_arbiter

Two-port arbiter that shares a single external memory handshake port between the instruction fetcher (`instr_*`) and the load/store unit (`data_*`) of the rv32imc_ss core. It is placed between the core's two master interfaces and a unified memory bus. It serialises one transaction at a time, registers the winning request onto the shared port, routes the response back to the granted master, and aborts hung transactions with a bus-error timeout.

## Interface
- `DATA_PRIORITY`, default 1: 1 gives fixed priority to the data port; 0 selects round-robin.
- `TIMEOUT_CYCLES`, default 255: number of busy cycles without a response before abort; 0 disables the timeout.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `instr_req`  in  1  fetch request, held until ack/err
- `instr_addr`  in  32  fetch address
- `instr_ack`  out  1  fetch complete, 1-cycle pulse
- `instr_err`  out  1  fetch failed, 1-cycle pulse
- `instr_data_i`  out  32  fetched word, valid with `instr_ack`
- `data_req`  in  1  LSU request, held until ack/err
- `data_wr`  in  1  1 = store
- `data_be`  in  4  byte enables
- `data_addr`  in  32  LSU address
- `data_data_o`  in  32  store data
- `data_ack`  out  1  LSU complete, 1-cycle pulse
- `data_err`  out  1  LSU failed, 1-cycle pulse
- `data_data_i`  out  32  load data, valid with `data_ack`
- `mem_req`  out  1  shared port request (registered)
- `mem_wr`  out  1  shared port write (registered)
- `mem_be`  out  4  shared port byte enables (registered)
- `mem_addr`  out  32  shared port address (registered)
- `mem_data_o`  out  32  shared port write data (registered)
- `mem_ack`  in  1  memory response ok
- `mem_err`  in  1  memory response error
- `mem_data_i`  in  32  memory read data

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE, no request: stay in IDLE; `mem_req`=0.
- IDLE, exactly one request: grant that requester.
- IDLE, both requests, `DATA_PRIORITY`=1: data wins.
- IDLE, both requests, `DATA_PRIORITY`=0: the port not granted last wins. `last_grant` resets to instr, so data wins the first tie.
- On grant: latch addr/wr/be/data into the `mem_*` registers and set `mem_req`=1. For an instr grant, `mem_wr`=0 and `mem_be`=4'hF.
- GRANT_x: `mem_*` outputs stay stable until a response arrives.
- Response routing: `mem_ack`, `mem_err` and `mem_data_i` go combinationally to the granted port only. The other port's ack/err stay 0 and its data outputs stay 0.
- On response: clear `mem_req` on the next edge, update `last_grant`, return to IDLE.
- `mem_err` and `mem_ack` in the same cycle: err wins and ack is suppressed.
- Timeout: the busy counter resets on grant and increments each GRANT_x cycle.
  - When the counter reaches `TIMEOUT_CYCLES` with no response, pulse err to the granted port, drop `mem_req`, and return to IDLE.
  - A response arriving in the timeout cycle is routed normally and no timeout fires.
- Requester rule: the master deasserts req in the cycle after ack/err unless it is issuing a new request. The arbiter ignores req while that master is not granted.
- A master that drops req while granted is a protocol violation. The transaction still completes on the bus and the response is dropped.
- Reset asserted at any time: state→IDLE, all outputs→0 immediately, counter→0, `last_grant`→instr. An in-flight bus transaction is abandoned.

## Timing
- Request to `mem_req` is 1 cycle: req sampled in IDLE at edge N, `mem_req` high from N.
- `mem_ack` to master ack is 0 cycles (same cycle).
- Back-to-back requests: one IDLE cycle sits between consecutive transactions. Minimum 3 cycles per transaction with single-cycle memory.
- The losing master waits through the whole winning transaction plus that IDLE cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Structure
- Package `rv32_pkg_bus` holds:
  - `arb_state_t` enum {IDLE, GRANT_I, GRANT_D}
  - `bus_grant_t` enum {GRANT_INSTR, GRANT_DATA}
  - localparam `BE_WORD` = 4'hF
- Sub-module `rv32_mod_bus_timeout` (clear, enable, expired; parameter `TIMEOUT_CYCLES`) contains the saturating counter. It is instantiated once.

## Test plan
- Single fetch: `instr_req`=1, addr 0x10000000, memory acks 2 cycles after `mem_req` with 0x00000013. Expect `mem_addr`=0x10000000, `mem_be`=F, `mem_wr`=0, and `instr_ack` pulse with `instr_data_i`=0x00000013.
- Contention, `DATA_PRIORITY`=1: both req high in the same cycle, store addr 0x80000004, be=4'b0011, data 0xDEADBEEF. Data is served first with `mem_wr`=1 and `mem_be`=3. Instr is served next after one IDLE cycle.
- Round-robin, `DATA_PRIORITY`=0: both masters hold requests continuously for 4 transactions. Grants alternate D, I, D, I.
- Error path: `mem_err` and `mem_ack` high together during a load. Expect `data_err`=1, `data_ack`=0, `instr_*` outputs 0.
- Timeout, `TIMEOUT_CYCLES`=8: memory never responds. Expect `instr_err` pulse 8 cycles after grant, `mem_req`=0 the next cycle, and a pending data request granted afterwards.
- Reset mid-transaction: assert reset during GRANT_D. Expect `mem_req` and all acks 0 without waiting for a clock edge. After release, the first tie goes to data.
